// File: rtl/burst_line_adaptor_pkg.sv
// Shared types for the burst line adaptor: FSM state, operation type and a
// line-alignment helper for 32-bit addresses.
package burst_line_adaptor_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_BOTH  = 2'd2
  } op_t;

  // Clear the byte-offset bits of an address for a line of line_bytes bytes.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned       line_bytes);
    return addr & ~(ADDR_W'(line_bytes) - ADDR_W'(1));
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat counter for one burst phase: counts accepted beats modulo BEATS.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clear       restart the count at 0 (new operation)
//   advance     one beat completed this cycle
//   count       current beat index (registered)
//   term_c      count is at the last beat of the phase (combinational)
module beat_counter #(
  parameter  int unsigned BEATS = 4,
  localparam int unsigned CNT_W = $clog2(BEATS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             term_c
);

  assign term_c = (count == CNT_W'(BEATS - 1));

  // Wrap to 0 on the terminal beat so the next phase starts at beat 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= term_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/burst_line_adaptor.sv
// Converts cacheline fill/writeback requests into memory bursts of BURST_W
// beats. A combined request writes the victim line back before filling.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   read_i, write_i            fill / writeback request levels, held until resp_o
//   address_i, wb_address_i    fill address, writeback address (combined op)
//   line_i, line_o             writeback data in, fill data out
//   resp_o, busy_o             completion pulse, not-idle indication
//   burst_i, burst_o           memory read beat in, memory write beat out
//   address_o, read_o, write_o line-aligned memory address and strobes
//   resp_i                     memory beat accept / beat valid
module burst_line_adaptor
  import burst_line_adaptor_pkg::*;
#(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [ADDR_W-1:0]  wb_address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic               busy_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned BEATS      = LINE_W / BURST_W;
  localparam int unsigned CNT_W      = $clog2(BEATS);
  localparam int unsigned LINE_BYTES = LINE_W / 8;

  // The line must split into a power-of-two number (>= 2) of whole beats.
  if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || BEATS * BURST_W != LINE_W) begin : g_bad_cfg
    $error("burst_line_adaptor: LINE_W/BURST_W must be a power of 2 and >= 2");
  end

  state_t             state;
  op_t                op;
  logic [BURST_W-1:0] wbuf [BEATS];
  logic [BURST_W-1:0] rbuf [BEATS];
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   next_idx;
  logic               term_c;
  logic               accept_c;
  logic               beat_c;
  logic [ADDR_W-1:0]  rd_aligned_c;
  logic [ADDR_W-1:0]  wr_aligned_c;

  assign accept_c     = (state == ST_IDLE) && (read_i || write_i);
  assign beat_c       = resp_i && ((state == ST_WRITE) || (state == ST_READ));
  assign next_idx     = count + CNT_W'(1);
  assign rd_aligned_c = line_align(address_i, LINE_BYTES);
  // A write-only op writes back to the fill address; a combined op uses wb_address_i.
  assign wr_aligned_c = line_align((read_i && write_i) ? wb_address_i : address_i, LINE_BYTES);

  beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept_c),
    .advance (beat_c),
    .count   (count),
    .term_c  (term_c)
  );

  // Fill data is the read buffer itself; beat 0 is the least significant.
  for (genvar g = 0; g < int'(BEATS); g++) begin : g_line_o
    assign line_o[g*BURST_W +: BURST_W] = rbuf[g];
  end

  // Control FSM with registered memory-side and upstream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op        <= OP_READ;
      wr_addr   <= '0;
      rd_addr   <= '0;
      resp_o    <= 1'b0;
      busy_o    <= 1'b0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      address_o <= '0;
      burst_o   <= '0;
      for (int i = 0; i < int'(BEATS); i++) begin
        wbuf[i] <= '0;
        rbuf[i] <= '0;
      end
    end else begin
      resp_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            for (int i = 0; i < int'(BEATS); i++) begin
              wbuf[i] <= line_i[i*BURST_W +: BURST_W];
            end
            rd_addr <= rd_aligned_c;
            wr_addr <= wr_aligned_c;
            burst_o <= line_i[BURST_W-1:0];
            busy_o  <= 1'b1;
            if (write_i) begin
              op        <= read_i ? OP_BOTH : OP_WRITE;
              state     <= ST_WRITE;
              write_o   <= 1'b1;
              address_o <= wr_aligned_c;
            end else begin
              op        <= OP_READ;
              state     <= ST_READ;
              read_o    <= 1'b1;
              address_o <= rd_aligned_c;
            end
          end
        end
        ST_WRITE: begin
          if (resp_i) begin
            // Present the following beat so each accept sees fresh data next cycle.
            burst_o <= wbuf[next_idx];
            if (term_c) begin
              write_o <= 1'b0;
              if (op == OP_BOTH) begin
                state     <= ST_READ;
                read_o    <= 1'b1;
                address_o <= rd_addr;
              end else begin
                state  <= ST_DONE;
                resp_o <= 1'b1;
              end
            end
          end
        end
        ST_READ: begin
          if (resp_i) begin
            rbuf[count] <= burst_i;
            if (term_c) begin
              read_o <= 1'b0;
              state  <= ST_DONE;
              resp_o <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
